// File: rtl/instruction_decode_pkg.sv
// Shared definitions for the instruction decode stage: opcode values,
// ALU operation encodings, the register-address width and the bundle of
// control signals carried from ID into EX.
package instruction_decode_pkg;

   localparam int REG_AW  = 5;
   localparam int INSTR_W = 32;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'b00,
      ALUOP_SUB   = 2'b01,
      ALUOP_FUNCT = 2'b10
   } alu_op_e;

   typedef struct packed {
      logic    regDst;
      logic    aluSrc;
      logic    memToReg;
      logic    regWrite;
      logic    memRead;
      logic    memWrite;
      logic    branch;
      alu_op_e aluOp;
   } ctrl_t;

endpackage

// File: rtl/instruction_decode_if.sv
// Bus between the decode stage and its neighbours.
//   master: the upstream side (fetch, WB, EX hazard info, branch flush)
//           drives the fetch/WB/EX inputs and receives the ID/EX outputs.
//   slave : the decode stage itself.
// Signals: instruction, pc_incrementado, flush, reg_write_wb, write_reg_wb,
// write_data_wb, mem_read_ex, rt_ex into decode; pc_write, the registered
// operands, immediate, register fields and control out of decode.
interface instruction_decode_if #(parameter int DATA_W = 32);
   import instruction_decode_pkg::*;

   logic [INSTR_W-1:0] instruction;
   logic [DATA_W-1:0]  pc_incrementado;
   logic               flush;
   logic               reg_write_wb;
   logic [REG_AW-1:0]  write_reg_wb;
   logic [DATA_W-1:0]  write_data_wb;
   logic               mem_read_ex;
   logic [REG_AW-1:0]  rt_ex;

   logic               pc_write;
   logic [DATA_W-1:0]  pc_incrementado_out;
   logic [DATA_W-1:0]  read_data_1;
   logic [DATA_W-1:0]  read_data_2;
   logic [DATA_W-1:0]  sign_extend;
   logic [REG_AW-1:0]  rs_out;
   logic [REG_AW-1:0]  rt_out;
   logic [REG_AW-1:0]  rd_out;
   logic               reg_dst;
   logic               alu_src;
   logic               mem_to_reg;
   logic               reg_write;
   logic               mem_read;
   logic               mem_write;
   logic               branch;
   logic [1:0]         alu_op;

   modport master (
      output instruction, pc_incrementado, flush, reg_write_wb, write_reg_wb,
             write_data_wb, mem_read_ex, rt_ex,
      input  pc_write, pc_incrementado_out, read_data_1, read_data_2,
             sign_extend, rs_out, rt_out, rd_out, reg_dst, alu_src,
             mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op
   );

   modport slave (
      input  instruction, pc_incrementado, flush, reg_write_wb, write_reg_wb,
             write_data_wb, mem_read_ex, rt_ex,
      output pc_write, pc_incrementado_out, read_data_1, read_data_2,
             sign_extend, rs_out, rt_out, rd_out, reg_dst, alu_src,
             mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op
   );

endinterface

// File: rtl/instruction_decode_register_file.sv
// Architectural register file: REG_N x DATA_W, two asynchronous read ports,
// one synchronous write port.
//   clk, reset              : pipeline clock, asynchronous active-low clear
//   i_readAddr1/2           : rs / rt read addresses
//   o_readData1/2           : read results (r0 always 0)
//   i_writeEn/Addr/Data     : write-back port
module register_file
   import instruction_decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] i_readAddr1,
   input  logic [REG_AW-1:0] i_readAddr2,
   output logic [DATA_W-1:0] o_readData1,
   output logic [DATA_W-1:0] o_readData2,
   input  logic              i_writeEn,
   input  logic [REG_AW-1:0] i_writeAddr,
   input  logic [DATA_W-1:0] i_writeData
);

   logic [DATA_W-1:0] r_regs [REG_N];
   logic              w_writeValid;

   assign w_writeValid = i_writeEn && (i_writeAddr != '0);

   // Storage: cleared on reset, written at the clock edge. r0 is never
   // written so it stays zero even if a write to it is requested.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < REG_N; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_writeValid) begin
         r_regs[i_writeAddr] <= i_writeData;
      end
   end

   // Read ports. A write landing this cycle is forwarded so that decode
   // sees the value WB is producing without waiting another cycle.
   always_comb begin
      o_readData1 = r_regs[i_readAddr1];
      if (i_readAddr1 == '0) begin
         o_readData1 = '0;
      end else if (w_writeValid && (i_writeAddr == i_readAddr1)) begin
         o_readData1 = i_writeData;
      end
   end

   always_comb begin
      o_readData2 = r_regs[i_readAddr2];
      if (i_readAddr2 == '0) begin
         o_readData2 = '0;
      end else if (w_writeValid && (i_writeAddr == i_readAddr2)) begin
         o_readData2 = i_writeData;
      end
   end

endmodule

// File: rtl/instruction_decode.sv
// Instruction decode stage of the five-stage MIPS pipeline: IF/ID latch,
// register file, main control decode, sign extension, load-use hazard
// detection and the ID/EX register.
//   clk   : pipeline clock, all state on the rising edge
//   reset : asynchronous active-low clear of all state
//   bus   : slave side of instruction_decode_if (fetch/WB/EX inputs,
//           pc_write back to fetch, registered ID/EX outputs)
module instruction_decode
   import instruction_decode_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_N  = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   instruction_decode_if.slave  bus
);

   logic [INSTR_W-1:0] r_ifInstr;
   logic [DATA_W-1:0]  r_ifPc;

   logic [5:0]         w_opcode;
   logic [REG_AW-1:0]  w_rs;
   logic [REG_AW-1:0]  w_rt;
   logic [REG_AW-1:0]  w_rd;
   logic [15:0]        w_imm;
   logic               w_stall;
   logic               w_bubble;
   ctrl_t              w_ctrl;
   logic [DATA_W-1:0]  w_readData1;
   logic [DATA_W-1:0]  w_readData2;

   ctrl_t              r_exCtrl;
   logic [DATA_W-1:0]  r_exPc;
   logic [DATA_W-1:0]  r_exReadData1;
   logic [DATA_W-1:0]  r_exReadData2;
   logic [DATA_W-1:0]  r_exSignExt;
   logic [REG_AW-1:0]  r_exRs;
   logic [REG_AW-1:0]  r_exRt;
   logic [REG_AW-1:0]  r_exRd;

   assign w_opcode = r_ifInstr[31:26];
   assign w_rs     = r_ifInstr[25:21];
   assign w_rt     = r_ifInstr[20:16];
   assign w_rd     = r_ifInstr[15:11];
   assign w_imm    = r_ifInstr[15:0];

   // Load-use hazard: the load in EX writes a register this instruction
   // reads. r0 is excluded because a load into r0 never produces a value.
   assign w_stall  = bus.mem_read_ex && (bus.rt_ex != '0) &&
                     ((bus.rt_ex == w_rs) || (bus.rt_ex == w_rt));
   assign w_bubble = w_stall || bus.flush;
   assign bus.pc_write = ~w_stall;

   // IF/ID latch. A flush replaces the fetched word with the all-zero nop
   // and takes priority over a stall, since the held instruction is dead.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ifInstr <= '0;
         r_ifPc    <= '0;
      end else if (bus.flush) begin
         r_ifInstr <= '0;
         r_ifPc    <= bus.pc_incrementado;
      end else if (!w_stall) begin
         r_ifInstr <= bus.instruction;
         r_ifPc    <= bus.pc_incrementado;
      end
   end

   // Main control decode from the opcode; unknown opcodes produce no
   // side effects at all.
   always_comb begin
      w_ctrl = '0;
      case (w_opcode)
         OP_RTYPE: begin
            w_ctrl.regDst   = 1'b1;
            w_ctrl.regWrite = 1'b1;
            w_ctrl.aluOp    = ALUOP_FUNCT;
         end
         OP_LW: begin
            w_ctrl.aluSrc   = 1'b1;
            w_ctrl.memToReg = 1'b1;
            w_ctrl.regWrite = 1'b1;
            w_ctrl.memRead  = 1'b1;
            w_ctrl.aluOp    = ALUOP_ADD;
         end
         OP_SW: begin
            w_ctrl.aluSrc   = 1'b1;
            w_ctrl.memWrite = 1'b1;
            w_ctrl.aluOp    = ALUOP_ADD;
         end
         OP_BEQ: begin
            w_ctrl.branch   = 1'b1;
            w_ctrl.aluOp    = ALUOP_SUB;
         end
         OP_ADDI: begin
            w_ctrl.aluSrc   = 1'b1;
            w_ctrl.regWrite = 1'b1;
            w_ctrl.aluOp    = ALUOP_ADD;
         end
         default: begin
            w_ctrl = '0;
         end
      endcase
   end

   register_file #(
      .DATA_W (DATA_W),
      .REG_N  (REG_N)
   ) u_registerFile (
      .clk         (clk),
      .reset       (reset),
      .i_readAddr1 (w_rs),
      .i_readAddr2 (w_rt),
      .o_readData1 (w_readData1),
      .o_readData2 (w_readData2),
      .i_writeEn   (bus.reg_write_wb),
      .i_writeAddr (bus.write_reg_wb),
      .i_writeData (bus.write_data_wb)
   );

   // ID/EX register. Stall and flush both insert a bubble by zeroing the
   // control bundle; the data fields load regardless since EX ignores them
   // when no control bit is set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_exCtrl      <= '0;
         r_exPc        <= '0;
         r_exReadData1 <= '0;
         r_exReadData2 <= '0;
         r_exSignExt   <= '0;
         r_exRs        <= '0;
         r_exRt        <= '0;
         r_exRd        <= '0;
      end else begin
         if (w_bubble) begin
            r_exCtrl <= '0;
         end else begin
            r_exCtrl <= w_ctrl;
         end
         r_exPc        <= r_ifPc;
         r_exReadData1 <= w_readData1;
         r_exReadData2 <= w_readData2;
         r_exSignExt   <= {{(DATA_W-16){w_imm[15]}}, w_imm};
         r_exRs        <= w_rs;
         r_exRt        <= w_rt;
         r_exRd        <= w_rd;
      end
   end

   assign bus.pc_incrementado_out = r_exPc;
   assign bus.read_data_1         = r_exReadData1;
   assign bus.read_data_2         = r_exReadData2;
   assign bus.sign_extend         = r_exSignExt;
   assign bus.rs_out              = r_exRs;
   assign bus.rt_out              = r_exRt;
   assign bus.rd_out              = r_exRd;
   assign bus.reg_dst             = r_exCtrl.regDst;
   assign bus.alu_src             = r_exCtrl.aluSrc;
   assign bus.mem_to_reg          = r_exCtrl.memToReg;
   assign bus.reg_write           = r_exCtrl.regWrite;
   assign bus.mem_read            = r_exCtrl.memRead;
   assign bus.mem_write           = r_exCtrl.memWrite;
   assign bus.branch              = r_exCtrl.branch;
   assign bus.alu_op              = r_exCtrl.aluOp;

endmodule

// File: tb/tb_instruction_decode.sv
// Self-checking bench for instruction_decode. Each instruction entering
// IF/ID pushes its expected ID/EX contents onto a scoreboard; the entry is
// popped and compared one edge later when the DUT presents it.
module tb_instruction_decode;

   // Control vector order: regDst aluSrc memToReg regWrite memRead
   // memWrite branch aluOp[1:0]
   localparam logic [8:0] CTRL_NONE = 9'b0_0_0_0_0_0_0_00;
   localparam logic [8:0] CTRL_R    = 9'b1_0_0_1_0_0_0_10;
   localparam logic [8:0] CTRL_LW   = 9'b0_1_1_1_1_0_0_00;
   localparam logic [8:0] CTRL_SW   = 9'b0_1_0_0_0_1_0_00;
   localparam logic [8:0] CTRL_BEQ  = 9'b0_0_0_0_0_0_1_01;
   localparam logic [8:0] CTRL_ADDI = 9'b0_1_0_1_0_0_0_00;

   typedef struct {
      logic [8:0]  ctrl;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] sext;
      logic [14:0] fields;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   instruction_decode_if bus ();

   instruction_decode dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [8:0]  actCtrl;
   logic [14:0] actFields;
   assign actCtrl   = {bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.reg_write,
                       bus.mem_read, bus.mem_write, bus.branch, bus.alu_op};
   assign actFields = {bus.rs_out, bus.rt_out, bus.rd_out};

   task automatic stepClk;
      @(posedge clk);
      #1;
   endtask

   task automatic idleInputs;
      bus.instruction     = 32'h0;
      bus.pc_incrementado = 32'h0;
      bus.flush           = 1'b0;
      bus.reg_write_wb    = 1'b0;
      bus.write_reg_wb    = 5'd0;
      bus.write_data_wb   = 32'h0;
      bus.mem_read_ex     = 1'b0;
      bus.rt_ex           = 5'd0;
   endtask

   // Outputs must stay zero across clock edges while reset is held.
   task automatic test_reset;
      logic [151:0] allOut;
      reset = 1'b0;
      idleInputs();
      bus.instruction = 32'h8C22FFFC;
      bus.mem_read_ex = 1'b1;
      bus.rt_ex       = 5'd1;
      stepClk();
      stepClk();
      allOut = {bus.pc_incrementado_out, bus.read_data_1, bus.read_data_2,
                bus.sign_extend, actFields, actCtrl};
      checks++;
      if (allOut !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs actual=%h required=0", allOut);
      end
      checks++;
      if (bus.pc_write !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_pc_write actual=%b required=1", bus.pc_write);
      end
      #3;
      reset = 1'b1;
      idleInputs();
   endtask

   // WB write forwarded into the same-cycle read, and writes to r0 ignored.
   task automatic test_write_read;
      exp_t e;
      bus.instruction = 32'h01091820;
      bus.pc_incrementado = 32'h100;
      stepClk();
      sb.push_back('{ctrl: CTRL_R, pc: 32'h100, rd1: 32'hAA, rd2: 32'h0,
                     sext: 32'h1820, fields: {5'd8, 5'd9, 5'd3}});
      bus.reg_write_wb  = 1'b1;
      bus.write_reg_wb  = 5'd8;
      bus.write_data_wb = 32'hAA;
      bus.instruction   = 32'h00080820;
      bus.pc_incrementado = 32'h104;
      stepClk();
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL wr_bypass scoreboard empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.read_data_1 !== e.rd1) begin
            errors++;
            $display("[TB] FAIL wr_bypass_rd1 actual=%h required=%h", bus.read_data_1, e.rd1);
         end
         checks++;
         if (actCtrl !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL wr_bypass_ctrl actual=%b required=%b", actCtrl, e.ctrl);
         end
         checks++;
         if (bus.pc_incrementado_out !== e.pc) begin
            errors++;
            $display("[TB] FAIL wr_bypass_pc actual=%h required=%h", bus.pc_incrementado_out, e.pc);
         end
      end
      // r0 write attempt while add r1,r0,r8 sits in ID
      sb.push_back('{ctrl: CTRL_R, pc: 32'h104, rd1: 32'h0, rd2: 32'hAA,
                     sext: 32'h0820, fields: {5'd0, 5'd8, 5'd1}});
      bus.write_reg_wb  = 5'd0;
      bus.write_data_wb = 32'hFFFF_FFFF;
      bus.pc_incrementado = 32'h108;
      stepClk();
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL wr_r0 scoreboard empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.read_data_1 !== e.rd1) begin
            errors++;
            $display("[TB] FAIL wr_r0_bypass actual=%h required=%h", bus.read_data_1, e.rd1);
         end
         checks++;
         if (bus.read_data_2 !== e.rd2) begin
            errors++;
            $display("[TB] FAIL wr_r8_stored actual=%h required=%h", bus.read_data_2, e.rd2);
         end
      end
      sb.push_back('{ctrl: CTRL_R, pc: 32'h108, rd1: 32'h0, rd2: 32'hAA,
                     sext: 32'h0820, fields: {5'd0, 5'd8, 5'd1}});
      bus.reg_write_wb = 1'b0;
      bus.instruction  = 32'h0;
      stepClk();
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL wr_r0_stored scoreboard empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.read_data_1 !== e.rd1) begin
            errors++;
            $display("[TB] FAIL wr_r0_stored actual=%h required=%h", bus.read_data_1, e.rd1);
         end
      end
      idleInputs();
   endtask

   // Streams one instruction per cycle; mem_read_ex is held with rt_ex=0,
   // which must never stall even for instructions reading r0.
   task automatic test_back_to_back;
      logic [31:0] tInstr [6];
      logic [8:0]  tCtrl  [6];
      logic [31:0] tSext  [6];
      logic [14:0] tField [6];
      exp_t e;
      tInstr = '{32'h8C22FFFC, 32'hAC220010, 32'h10220003,
                 32'h20057FFF, 32'hFCA63800, 32'h00432020};
      tCtrl  = '{CTRL_LW, CTRL_SW, CTRL_BEQ, CTRL_ADDI, CTRL_NONE, CTRL_R};
      tSext  = '{32'hFFFF_FFFC, 32'h0000_0010, 32'h0000_0003,
                 32'h0000_7FFF, 32'h0000_3800, 32'h0000_2020};
      tField = '{{5'd1, 5'd2, 5'd31}, {5'd1, 5'd2, 5'd0}, {5'd1, 5'd2, 5'd0},
                 {5'd0, 5'd5, 5'd15}, {5'd5, 5'd6, 5'd7}, {5'd2, 5'd3, 5'd4}};
      bus.mem_read_ex = 1'b1;
      bus.rt_ex       = 5'd0;
      bus.instruction = tInstr[0];
      bus.pc_incrementado = 32'h600;
      stepClk();
      sb.push_back('{ctrl: tCtrl[0], pc: 32'h600, rd1: 32'h0, rd2: 32'h0,
                     sext: tSext[0], fields: tField[0]});
      for (int i = 1; i <= 6; i++) begin
         bus.instruction     = (i < 6) ? tInstr[i] : 32'h0;
         bus.pc_incrementado = 32'h600 + 32'(4 * i);
         stepClk();
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL b2b_%0d scoreboard empty", i - 1);
         end else begin
            e = sb.pop_front();
            checks++;
            if (actCtrl !== e.ctrl) begin
               errors++;
               $display("[TB] FAIL b2b_%0d_ctrl actual=%b required=%b", i - 1, actCtrl, e.ctrl);
            end
            checks++;
            if (bus.sign_extend !== e.sext) begin
               errors++;
               $display("[TB] FAIL b2b_%0d_sext actual=%h required=%h", i - 1, bus.sign_extend, e.sext);
            end
            checks++;
            if (actFields !== e.fields) begin
               errors++;
               $display("[TB] FAIL b2b_%0d_fields actual=%h required=%h", i - 1, actFields, e.fields);
            end
            checks++;
            if (bus.pc_incrementado_out !== e.pc) begin
               errors++;
               $display("[TB] FAIL b2b_%0d_pc actual=%h required=%h", i - 1, bus.pc_incrementado_out, e.pc);
            end
         end
         if (i < 6) begin
            sb.push_back('{ctrl: tCtrl[i], pc: 32'h600 + 32'(4 * i), rd1: 32'h0,
                           rd2: 32'h0, sext: tSext[i], fields: tField[i]});
         end
      end
      idleInputs();
   endtask

   // Load-use stall on add r4,r2,r3 behind a load of r2.
   task automatic test_stall;
      exp_t e;
      bus.instruction = 32'h00432020;
      bus.pc_incrementado = 32'h200;
      stepClk();
      bus.mem_read_ex = 1'b1;
      bus.rt_ex = 5'd3;
      #1;
      checks++;
      if (bus.pc_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_rt_match actual=%b required=0", bus.pc_write);
      end
      bus.rt_ex = 5'd7;
      #1;
      checks++;
      if (bus.pc_write !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_no_match actual=%b required=1", bus.pc_write);
      end
      bus.rt_ex = 5'd2;
      #1;
      checks++;
      if (bus.pc_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL stall_rs_match actual=%b required=0", bus.pc_write);
      end
      sb.push_back('{ctrl: CTRL_NONE, pc: 32'h0, rd1: 32'h0, rd2: 32'h0,
                     sext: 32'h0, fields: 15'h0});
      bus.instruction = 32'hAC220010;
      bus.pc_incrementado = 32'h204;
      stepClk();
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL stall_bubble scoreboard empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (actCtrl !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL stall_bubble_ctrl actual=%b required=%b", actCtrl, e.ctrl);
         end
      end
      bus.mem_read_ex = 1'b0;
      bus.rt_ex = 5'd0;
      #1;
      checks++;
      if (bus.pc_write !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_release actual=%b required=1", bus.pc_write);
      end
      sb.push_back('{ctrl: CTRL_R, pc: 32'h200, rd1: 32'h0, rd2: 32'h0,
                     sext: 32'h2020, fields: {5'd2, 5'd3, 5'd4}});
      stepClk();
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL stall_issue scoreboard empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (actCtrl !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL stall_issue_ctrl actual=%b required=%b", actCtrl, e.ctrl);
         end
         checks++;
         if (actFields !== e.fields) begin
            errors++;
            $display("[TB] FAIL stall_issue_fields actual=%h required=%h", actFields, e.fields);
         end
         checks++;
         if (bus.pc_incrementado_out !== e.pc) begin
            errors++;
            $display("[TB] FAIL stall_held_pc actual=%h required=%h", bus.pc_incrementado_out, e.pc);
         end
      end
      idleInputs();
   endtask

   // Flush of a beq in ID, then flush combined with a load-use stall.
   task automatic test_flush;
      exp_t e;
      for (int pass = 0; pass < 2; pass++) begin
         bus.instruction = (pass == 0) ? 32'h10220003 : 32'h00432020;
         bus.pc_incrementado = 32'h300 + 32'(pass * 32'h100);
         stepClk();
         bus.flush = 1'b1;
         if (pass == 1) begin
            bus.mem_read_ex = 1'b1;
            bus.rt_ex = 5'd2;
            #1;
            checks++;
            if (bus.pc_write !== 1'b0) begin
               errors++;
               $display("[TB] FAIL flush_stall_pc_write actual=%b required=0", bus.pc_write);
            end
         end
         sb.push_back('{ctrl: CTRL_NONE, pc: 32'h0, rd1: 32'h0, rd2: 32'h0,
                        sext: 32'h0, fields: 15'h0});
         bus.instruction = 32'h20057FFF;
         stepClk();
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL flush_%0d_bubble scoreboard empty", pass);
         end else begin
            e = sb.pop_front();
            checks++;
            if (actCtrl !== e.ctrl) begin
               errors++;
               $display("[TB] FAIL flush_%0d_bubble_ctrl actual=%b required=%b", pass, actCtrl, e.ctrl);
            end
         end
         bus.flush = 1'b0;
         bus.mem_read_ex = 1'b0;
         bus.rt_ex = 5'd0;
         // IF/ID must now hold the all-zero nop, which decodes as R-type
         sb.push_back('{ctrl: CTRL_R, pc: 32'h0, rd1: 32'h0, rd2: 32'h0,
                        sext: 32'h0, fields: 15'h0});
         bus.instruction = 32'h0;
         stepClk();
         if (sb.size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL flush_%0d_nop scoreboard empty", pass);
         end else begin
            e = sb.pop_front();
            checks++;
            if (actCtrl !== e.ctrl) begin
               errors++;
               $display("[TB] FAIL flush_%0d_nop_ctrl actual=%b required=%b", pass, actCtrl, e.ctrl);
            end
            checks++;
            if ({actFields, bus.sign_extend} !== {e.fields, e.sext}) begin
               errors++;
               $display("[TB] FAIL flush_%0d_nop_fields actual=%h/%h required=%h/%h",
                        pass, actFields, bus.sign_extend, e.fields, e.sext);
            end
         end
      end
      idleInputs();
   endtask

   // Reset asserted between edges clears outputs at once and wipes r5.
   task automatic test_reset_midstream;
      exp_t e;
      logic [151:0] allOut;
      bus.reg_write_wb  = 1'b1;
      bus.write_reg_wb  = 5'd5;
      bus.write_data_wb = 32'h55;
      bus.instruction   = 32'h00A00820;
      bus.pc_incrementado = 32'h500;
      stepClk();
      bus.reg_write_wb = 1'b0;
      sb.push_back('{ctrl: CTRL_R, pc: 32'h500, rd1: 32'h55, rd2: 32'h0,
                     sext: 32'h0820, fields: {5'd5, 5'd0, 5'd1}});
      bus.pc_incrementado = 32'h504;
      stepClk();
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL mid_r5_stored scoreboard empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.read_data_1 !== e.rd1) begin
            errors++;
            $display("[TB] FAIL mid_r5_stored actual=%h required=%h", bus.read_data_1, e.rd1);
         end
      end
      bus.mem_read_ex = 1'b1;
      bus.rt_ex = 5'd5;
      #1;
      checks++;
      if (bus.pc_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_prereset_stall actual=%b required=0", bus.pc_write);
      end
      #1;
      reset = 1'b0;
      #1;
      allOut = {bus.pc_incrementado_out, bus.read_data_1, bus.read_data_2,
                bus.sign_extend, actFields, actCtrl};
      checks++;
      if (allOut !== '0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs actual=%h required=0", allOut);
      end
      checks++;
      if (bus.pc_write !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_reset_pc_write actual=%b required=1", bus.pc_write);
      end
      #2;
      reset = 1'b1;
      bus.mem_read_ex = 1'b0;
      bus.rt_ex = 5'd0;
      stepClk();
      sb.push_back('{ctrl: CTRL_R, pc: 32'h504, rd1: 32'h0, rd2: 32'h0,
                     sext: 32'h0820, fields: {5'd5, 5'd0, 5'd1}});
      bus.instruction = 32'h0;
      stepClk();
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL mid_r5_cleared scoreboard empty");
      end else begin
         e = sb.pop_front();
         checks++;
         if (bus.read_data_1 !== e.rd1) begin
            errors++;
            $display("[TB] FAIL mid_r5_cleared actual=%h required=%h", bus.read_data_1, e.rd1);
         end
         checks++;
         if (actCtrl !== e.ctrl) begin
            errors++;
            $display("[TB] FAIL mid_post_ctrl actual=%b required=%b", actCtrl, e.ctrl);
         end
      end
      idleInputs();
   endtask

   initial begin
      $display("[TB] starting instruction_decode bench");
      test_reset();
      test_write_read();
      test_back_to_back();
      test_stall();
      test_flush();
      test_reset_midstream();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL scoreboard_leftover actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
- Second stage of the five-stage MIPS pipeline, directly downstream of instruction_fetch.
- Owns the IF/ID latch, the 32x32 register file, main control decode, sign extension, load-use hazard detection and the ID/EX output register.
- Drives pc_write back to instruction_fetch. Accepts flush from branch resolution and the write-back port from the WB stage.

Parameters:
- DATA_W, 32, datapath and register width
- REG_N, 32, number of architectural registers (address width log2(REG_N)=5)

Ports:
- clk  in  1  single pipeline clock; all state on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- instruction  in  32  from instruction_fetch
- pc_incrementado  in  32  PC+4 from instruction_fetch
- flush  in  1  branch taken (PCSrc); kill younger instructions
- reg_write_wb  in  1  WB write enable
- write_reg_wb  in  5  WB destination register
- write_data_wb  in  32  WB data
- mem_read_ex  in  1  instruction currently in EX is a load
- rt_ex  in  5  destination (rt) of the EX-stage load
- pc_write  out  1  0 = instruction_fetch must hold PC (combinational)
- pc_incrementado_out  out  32  registered PC+4
- read_data_1, read_data_2  out  32 each  registered rs/rt operands
- sign_extend  out  32  registered sign-extended imm[15:0]
- rs_out, rt_out, rd_out  out  5 each  registered register fields
- reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch  out  1 each  registered control
- alu_op  out  2  registered control

Behaviour:
- Reset (reset=0, asynchronous):
  - IF/ID instruction=0 (sll nop), IF/ID pc=0.
  - All 32 registers=0.
  - Every registered output=0.
- Reset deassertion: takes effect at the next rising edge. Reset mid-operation discards all in-flight instructions.
- IF/ID latch:
  - Loads instruction/pc_incrementado each edge unless stall=1; holds on stall.
  - flush=1 loads instruction=0 instead.
- Hazard detection (combinational on IF/ID contents):
  - stall = mem_read_ex & (rt_ex!=0) & (rt_ex==rs | rt_ex==rt).
  - pc_write = ~stall.
- Decode by opcode [31:26]:
  - 000000 R-type: reg_dst=1, reg_write=1, alu_op=10
  - 100011 lw: alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00
  - 101011 sw: alu_src=1, mem_write=1, alu_op=00
  - 000100 beq: branch=1, alu_op=01
  - 001000 addi: alu_src=1, reg_write=1, alu_op=00
  - any other opcode: all control 0
- Register file:
  - Two async read ports addressed by rs/rt; one write port, written on the rising edge when reg_write_wb=1 and write_reg_wb!=0.
  - r0 always reads 0.
  - Write-through bypass: if a read address equals write_reg_wb (nonzero) with reg_write_wb=1, the read returns write_data_wb in the same cycle.
- ID/EX register: latency 1 cycle from IF/ID to outputs.
  - On stall or flush, all control outputs load 0 (bubble). Data fields load normally (don't-care).
- Simultaneous flush and stall: flush wins.
  - IF/ID loads nop, ID/EX loads bubble, pc_write still follows stall.
- sign_extend = {{16{imm[15]}}, imm[15:0]}.
- pc_incrementado is passed through unmodified.

Decomposition:
- Shared include/package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI)
  - alu_op encodings (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - register-address width 5
- Sub-module: register_file (32x32, 2R/1W, r0 hardwired, write-through bypass).
- Control decode and hazard logic stay inline.

Test Plan:
- Reset: assert reset=0 mid-stream -> all outputs 0 immediately, pc_write=1; after release, reading r5 returns 0.
- Write then read, same cycle: WB writes r8=0x0000_00AA while IF/ID holds add r3,r8,r9 -> read_data_1=0x0000_00AA next edge. Write to r0 with 0xFFFF_FFFF -> r0 reads 0.
- lw decode: lw r2,-4(r1) (0x8C22FFFC) -> one cycle later:
  - mem_read=1, mem_to_reg=1, alu_src=1, reg_write=1, alu_op=00
  - sign_extend=0xFFFF_FFFC, rt_out=2
- Load-use stall: mem_read_ex=1, rt_ex=2, IF/ID holds add r4,r2,r3 -> pc_write=0, IF/ID held, ID/EX controls 0. Next cycle with mem_read_ex=0 -> add issues with reg_dst=1, alu_op=10.
- Flush: flush=1 while beq is in ID -> next edge IF/ID instruction=0 and ID/EX controls all 0. Same with stall active -> still bubble, IF/ID=0.
- Unknown opcode 0x3F -> all control outputs 0; rs_out/rt_out/rd_out still equal the instruction fields.
